snake_body_engine: RTL and testbench

- Owns the snake's segment list, which feeds the pixel renderer.
- On each game-step pulse it:
  - applies the latched direction to compute a new head;
  - pushes the new head into a circular segment memory;
  - grows the snake if an apple was eaten;
  - checks the new head against the border and the body, one segment per cycle.
- The renderer reads segment coordinates by index through a registered read port.

---
 rtl/snake_body_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake segment list: step FSM, body collision scan, registered read port
// Optional: define SNAKE_WRAP_EN to wrap the head around the borders instead of dying.
module snake_body_engine #(
  parameter int MAX_LEN = 128,
  parameter int CELL    = 10,
  parameter int X_MIN   = 10,
  parameter int X_MAX   = 620,
  parameter int Y_MIN   = 10,
  parameter int Y_MAX   = 460,
  parameter int START_X = 320,
  parameter int START_Y = 240
) (
  input  logic       master_clk,
  input  logic       B_reset_n,
  input  logic       start,
  input  logic       step,
  input  logic [4:0] dir,
  input  logic       grow,
  input  logic [6:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  output logic       rd_valid,
  output logic [9:0] head_x,
  output logic [8:0] head_y,
  output logic [7:0] length,
  output logic       busy,
  output logic       dead,
  output logic       step_done
);

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [4:0] D_UP = 5'b00010, D_LEFT = 5'b00100, D_DOWN = 5'b01000, D_RIGHT = 5'b10000;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MOVE, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [9:0]      head_x_q, head_x_d;
  logic [8:0]      head_y_q, head_y_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      scan_i_q, scan_i_d;
  logic [4:0]      last_dir_q, last_dir_d;
  logic            grow_pend_q, grow_pend_d;
  logic            dead_q, dead_d;
  logic            busy_q, busy_d;
  logic            step_done_q, step_done_d;
  logic [9:0]      rd_x_q, rd_x_d;
  logic [8:0]      rd_y_q, rd_y_d;
  logic            rd_valid_q, rd_valid_d;

  logic [18:0]     mem_q [MAX_LEN];
  logic            wr_en;
  logic [PW-1:0]   wr_addr, scan_addr, rd_addr;
  logic [18:0]     wr_data;

  logic [10:0]     nx, wx;
  logic [9:0]      ny, wy;
  logic            border_dead, dir_ok, scan_hit;
  logic [4:0]      dir_opp;

  // Next head computed on widened coordinates so a step below zero is not aliased to a legal value
  always_comb begin
    nx = {1'b0, head_x_q};
    ny = {1'b0, head_y_q};
    case (last_dir_q)
      D_UP:    ny = ny - 10'(CELL);
      D_DOWN:  ny = ny + 10'(CELL);
      D_LEFT:  nx = nx - 11'(CELL);
      default: nx = nx + 11'(CELL);
    endcase
`ifdef SNAKE_WRAP_EN
    wx = (nx < 11'(X_MIN)) ? 11'(X_MAX) : (nx > 11'(X_MAX)) ? 11'(X_MIN) : nx;
    wy = (ny < 10'(Y_MIN)) ? 10'(Y_MAX) : (ny > 10'(Y_MAX)) ? 10'(Y_MIN) : ny;
    border_dead = 1'b0;
`else
    wx = nx;
    wy = ny;
    border_dead = (nx < 11'(X_MIN)) || (nx > 11'(X_MAX)) || (ny < 10'(Y_MIN)) || (ny > 10'(Y_MAX));
`endif
  end

  always_comb begin
    dir_opp   = {last_dir_q[2], last_dir_q[1], last_dir_q[4], last_dir_q[3], 1'b0};
    dir_ok    = (dir == D_UP || dir == D_LEFT || dir == D_DOWN || dir == D_RIGHT) && (dir != dir_opp);
    scan_addr = ptr_q + scan_i_q[PW-1:0];
    scan_hit  = (mem_q[scan_addr] == {head_x_q, head_y_q});
    rd_addr   = ptr_q + rd_idx[PW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    len_d       = len_q;
    scan_i_d    = scan_i_q;
    last_dir_d  = dir_ok ? dir : last_dir_q;
    grow_pend_d = grow_pend_q | (start & grow);
    dead_d      = dead_q;
    busy_d      = busy_q;
    step_done_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = ptr_q - 1'b1;
    wr_data     = {wx[9:0], wy[8:0]};

    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (step && !dead_q) begin
          state_d = S_MOVE;
          busy_d  = 1'b1;
        end
      end
      S_MOVE: begin
        ptr_d    = ptr_q - 1'b1;
        wr_en    = 1'b1;
        head_x_d = wx[9:0];
        head_y_d = wy[8:0];
        if (grow_pend_q && len_q < 8'(MAX_LEN)) len_d = len_q + 8'd1;
        grow_pend_d = start & grow;
        if (border_dead) dead_d = 1'b1;
        scan_i_d = 8'd1;
        if (len_d == 8'd1) begin
          state_d     = S_DONE;
          step_done_d = 1'b1;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_hit) dead_d = 1'b1;
        if (scan_i_q == len_q - 8'd1) begin
          state_d     = S_DONE;
          step_done_d = 1'b1;
        end else begin
          scan_i_d = scan_i_q + 8'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Holding in INIT rewrites segment 0 so a later growth finds the start cell behind the head
    if (!start || state_q == S_INIT) begin
      ptr_d       = '0;
      head_x_d    = 10'(START_X);
      head_y_d    = 9'(START_Y);
      len_d       = 8'd1;
      scan_i_d    = 8'd0;
      last_dir_d  = D_RIGHT;
      grow_pend_d = 1'b0;
      dead_d      = 1'b0;
      busy_d      = 1'b0;
      step_done_d = 1'b0;
      wr_en       = 1'b1;
      wr_addr     = '0;
      wr_data     = {10'(START_X), 9'(START_Y)};
      if (!start) state_d = S_INIT;
    end

    rd_valid_d = ({1'b0, rd_idx} < len_q);
    if (!rd_valid_d) begin
      rd_x_d = 10'd700;
      rd_y_d = 9'd500;
    end else if (rd_idx == 7'd0) begin
      rd_x_d = head_x_q;
      rd_y_d = head_y_q;
    end else begin
      {rd_x_d, rd_y_d} = mem_q[rd_addr];
    end
  end

  always_ff @(posedge master_clk or negedge B_reset_n) begin
    if (!B_reset_n) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      head_x_q    <= 10'(START_X);
      head_y_q    <= 9'(START_Y);
      len_q       <= 8'd1;
      scan_i_q    <= 8'd0;
      last_dir_q  <= D_RIGHT;
      grow_pend_q <= 1'b0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      rd_x_q      <= 10'd700;
      rd_y_q      <= 9'd500;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      len_q       <= len_d;
      scan_i_q    <= scan_i_d;
      last_dir_q  <= last_dir_d;
      grow_pend_q <= grow_pend_d;
      dead_q      <= dead_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_ff @(posedge master_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;
  assign rd_valid  = rd_valid_q;
  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = len_q;
  assign busy      = busy_q;
  assign dead      = dead_q;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed and randomized bench for snake_body_engine with a queue-based snake model
module tb_snake_body_engine;

  localparam int MAX_LEN = 128;
  localparam int CELL = 10;

  logic       master_clk = 1'b0;
  logic       B_reset_n = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic [4:0] dir = 5'd0;
  logic       grow = 1'b0;
  logic [6:0] rd_idx = 7'd0;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_valid;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic [7:0] length;
  logic       busy;
  logic       dead;
  logic       step_done;

  snake_body_engine dut (
    .master_clk(master_clk), .B_reset_n(B_reset_n), .start(start), .step(step), .dir(dir),
    .grow(grow), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy), .dead(dead),
    .step_done(step_done)
  );

  always #10 master_clk = ~master_clk;

  int checks = 0;
  int failures = 0;

  // Model: queue of segments, head at index 0; direction code 0 up, 1 left, 2 down, 3 right
  int mx[$];
  int my[$];
  int m_dir;
  bit m_grow;
  bit m_dead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mx = {320};
    my = {240};
    m_dir = 3;
    m_grow = 0;
    m_dead = 0;
  endtask

  task automatic m_apply_dir(input logic [4:0] d);
    int c;
    case (d)
      5'b00010: c = 0;
      5'b00100: c = 1;
      5'b01000: c = 2;
      5'b10000: c = 3;
      default:  c = -1;
    endcase
    if (c >= 0 && c != (m_dir + 2) % 4) m_dir = c;
  endtask

  task automatic m_step(output int lat);
    int hx, hy;
    bit grow_ok;
    if (m_dead) begin
      lat = -1;
      return;
    end
    hx = mx[0];
    hy = my[0];
    case (m_dir)
      0: hy -= CELL;
      1: hx -= CELL;
      2: hy += CELL;
      default: hx += CELL;
    endcase
`ifdef SNAKE_WRAP_EN
    if (hx < 10) hx = 620; else if (hx > 620) hx = 10;
    if (hy < 10) hy = 460; else if (hy > 460) hy = 10;
`else
    if (hx < 10 || hx > 620 || hy < 10 || hy > 460) m_dead = 1;
`endif
    grow_ok = m_grow && (mx.size() < MAX_LEN);
    mx.push_front(hx);
    my.push_front(hy);
    if (!grow_ok) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    m_grow = 0;
    for (int i = 1; i < mx.size(); i++)
      if (mx[i] == hx && my[i] == hy) m_dead = 1;
    lat = mx.size() + 1;
  endtask

  task automatic pulse(input logic [4:0] d, input logic g);
    @(negedge master_clk);
    dir = d;
    grow = g;
    @(negedge master_clk);
    dir = 5'd0;
    grow = 1'b0;
    m_apply_dir(d);
    if (g) m_grow = 1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_hx"}, 32'(head_x), mx[0]);
    chk({tag, "_hy"}, 32'(head_y), my[0]);
    chk({tag, "_len"}, 32'(length), mx.size());
    chk({tag, "_dead"}, 32'(dead), 32'(m_dead));
  endtask

  // Latency counts clock edges from the edge sampling step to the edge that sees step_done high
  task automatic do_step();
    int exp_lat;
    int p;
    m_step(exp_lat);
    @(negedge master_clk);
    step = 1'b1;
    @(negedge master_clk);
    step = 1'b0;
    if (exp_lat < 0) begin
      chk("ign_busy0", 32'(busy), 0);
      repeat (3) @(negedge master_clk);
      chk("ign_busy", 32'(busy), 0);
    end else begin
      chk("busy_set", 32'(busy), 1);
      p = 0;
      while (step_done !== 1'b1 && p < 400) begin
        @(negedge master_clk);
        p++;
      end
      chk("step_lat", p + 1, exp_lat);
      @(negedge master_clk);
      chk("done_clr", {30'd0, step_done, busy}, 0);
    end
    check_state("step");
  endtask

  task automatic check_read(input int idx);
    @(negedge master_clk);
    rd_idx = 7'(idx);
    @(negedge master_clk);
    if (idx < mx.size()) begin
      chk("rd_x", 32'(rd_x), mx[idx]);
      chk("rd_y", 32'(rd_y), my[idx]);
      chk("rd_valid", 32'(rd_valid), 1);
    end else begin
      chk("rd_x_sent", 32'(rd_x), 700);
      chk("rd_y_sent", 32'(rd_y), 500);
      chk("rd_valid_sent", 32'(rd_valid), 0);
    end
  endtask

  task automatic reinit();
    @(negedge master_clk);
    start = 1'b0;
    @(negedge master_clk);
    @(negedge master_clk);
    start = 1'b1;
    @(negedge master_clk);
    m_reset();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sd_count;
    int lim;
    logic [4:0] d;
    m_reset();
    repeat (3) @(negedge master_clk);
    chk("rst_len", 32'(length), 1);
    chk("rst_hx", 32'(head_x), 320);
    chk("rst_hy", 32'(head_y), 240);
    chk("rst_flags", {29'd0, dead, busy, step_done}, 0);
    chk("rst_rdx", 32'(rd_x), 700);
    chk("rst_rdy", 32'(rd_y), 500);
    chk("rst_rdv", 32'(rd_valid), 0);
    B_reset_n = 1'b1;
    @(negedge master_clk);
    start = 1'b1;
    @(negedge master_clk);

    // First step moves right from the start cell
    do_step();
    chk("t1_hx", 32'(head_x), 330);
    chk("t1_len", 32'(length), 1);

    // Grow and turn down, then read behind the head and past the tail
    pulse(5'b01000, 1'b1);
    do_step();
    chk("t2_hy", 32'(head_y), 250);
    chk("t2_len", 32'(length), 2);
    check_read(1);
    check_read(2);

    // Reversal and non-one-hot requests are ignored
    pulse(5'b10000, 1'b0);
    do_step();
    pulse(5'b00100, 1'b0);
    do_step();
    chk("t3_rev_x", 32'(head_x), 350);
    pulse(5'b01100, 1'b0);
    do_step();
    chk("t3_nonhot_x", 32'(head_x), 360);

    // Run up into the top border
    reinit();
    do_step();
    pulse(5'b00010, 1'b0);
    repeat (23) do_step();
    chk("t4_top_y", 32'(head_y), 10);
    do_step();
`ifdef SNAKE_WRAP_EN
    chk("t4_wrap_y", 32'(head_y), 460);
    chk("t4_wrap_dead", 32'(dead), 0);
`else
    chk("t4_dead", 32'(dead), 1);
    chk("t4_len", 32'(length), 1);
`endif
    do_step();

    // Length 5 square turn bites segment 4
    reinit();
    repeat (4) begin
      pulse(5'b00000, 1'b1);
      do_step();
    end
    chk("t5_len", 32'(length), 5);
    pulse(5'b01000, 1'b0);
    do_step();
    pulse(5'b00100, 1'b0);
    do_step();
    pulse(5'b00010, 1'b0);
    do_step();
    chk("t5_dead", 32'(dead), 1);
    check_read(4);

    // Drop start in the middle of a scan
    reinit();
    repeat (4) begin
      pulse(5'b00000, 1'b1);
      do_step();
    end
    @(negedge master_clk);
    step = 1'b1;
    @(negedge master_clk);
    step = 1'b0;
    @(negedge master_clk);
    start = 1'b0;
    @(negedge master_clk);
    m_reset();
    check_state("t6");
    chk("t6_busy", {30'd0, busy, step_done}, 0);
    start = 1'b1;
    sd_count = 0;
    repeat (6) begin
      @(negedge master_clk);
      if (step_done === 1'b1) sd_count++;
    end
    chk("t6_no_done", sd_count, 0);
    check_read(0);
    check_read(1);

    // Random walk against the model
    reinit();
    for (int n = 0; n < 200; n++) begin
      if (m_dead) begin
        do_step();
        reinit();
      end else begin
        if ($urandom_range(0, 9) < 2) d = 5'($urandom_range(0, 31));
        else d = 5'(1 << $urandom_range(1, 4));
        pulse(d, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        do_step();
        lim = (mx.size() + 1 > 127) ? 127 : mx.size() + 1;
        check_read($urandom_range(0, lim));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
